ring_arbiter: RTL and testbench
===============================

RING_ARBITER -- requirements
Module: ring_arbiter

Interface
REQ-001 The block SHALL have parameter QUANTUM, default 8, meaning the maximum consecutive grant cycles per holder (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port clr, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 4 bits: request per requester, index 0..3, level-sensitive.
REQ-005 The block SHALL have port mask, input, 4 bits: 1 = requester enabled, 0 = requester ineligible.
REQ-006 The block SHALL have port gnt, output, 4 bits: one-hot grant, registered.
REQ-007 The block SHALL have port gnt_id, output, 2 bits: index of the current holder, 0 when gnt==0.
REQ-008 The block SHALL have port ptr, output, 4 bits: one-hot ring priority pointer, registered.
REQ-009 The block SHALL have port preempt, output, 1 bit: one-cycle pulse when a grant ends by quantum expiry.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, GRANT and GAP.
REQ-011 The eligible set SHALL be defined as req & mask.
REQ-012 Priority order SHALL start at the ptr bit and descend by index with wrap: ptr=1000 gives order 3,2,1,0 and ptr=0010 gives order 1,0,3,2.
REQ-013 In IDLE with a non-empty eligible set, the block SHALL select the first eligible index in priority order and enter GRANT; gnt is asserted the following cycle (one-cycle latency from req to gnt).
REQ-014 In IDLE with an empty eligible set, the block SHALL stay in IDLE with gnt=0000 and ptr unchanged.
REQ-015 On the grant to index i, ptr SHALL load the one-hot of (i-1) mod 4 (the ring rotated one place past the winner), so the winner becomes lowest priority.
REQ-016 The hold counter (8 bits) SHALL load 1 on entry to GRANT.
REQ-017 In GRANT, when req[i]&mask[i]==0, the block SHALL go to GAP, with gnt=0000 on the next cycle and preempt=0.
REQ-018 In GRANT, when the holder is still eligible and the counter equals QUANTUM, the block SHALL go to GAP with preempt=1 for exactly that next cycle, so a grant lasts at most QUANTUM cycles.
REQ-019 In GRANT otherwise, the counter SHALL increment and gnt SHALL hold unchanged.
REQ-020 GAP SHALL last exactly one cycle with gnt=0000, followed by IDLE; the minimum spacing between grants is therefore two idle cycles.
REQ-021 A preempted requester still asserting req SHALL compete normally under the rotated ptr and SHALL get no special priority.
REQ-022 Changes to req or mask outside the current holder's bit SHALL NOT affect an active grant.
REQ-023 gnt SHALL never have more than one bit set, and gnt_id SHALL always equal the encoded value of gnt.
REQ-024 When a single requester stays continuously eligible and alone, it SHALL be regranted after each GAP and preempted every QUANTUM cycles.

Reset
REQ-025 While clr=0, the block SHALL immediately (asynchronously) force state=IDLE, gnt=0000, gnt_id=00, ptr=1000, preempt=0 and counter=0.
REQ-026 When clr is asserted mid-grant, the grant SHALL drop without passing through GAP.
REQ-027 After clr deasserts, the first arbitration SHALL occur on the next rising edge in IDLE.

Verification
REQ-028 The bench SHALL check reset then req=1111, mask=1111: grants go to 3,2,1,0,3 in order, with ptr after each grant being 0100, 0010, 0001, 1000.
REQ-029 The bench SHALL check req=0001 held high with QUANTUM=8: gnt=0001 for exactly 8 cycles, preempt pulses once, 2 idle cycles, then regrant, repeating.
REQ-030 The bench SHALL check holder 2 dropping req on its 3rd grant cycle: gnt=0000 next cycle, preempt=0, and the next grant goes to the next eligible index below 2.
REQ-031 The bench SHALL check req=1111 with mask=0101: only indices 2 and 0 are granted, alternating.
REQ-032 The bench SHALL check clr pulsed low mid-grant of index 1: gnt=0000 and ptr=1000 immediately, with no preempt pulse.
REQ-033 The bench SHALL check that with req=0000 for 20 cycles, gnt stays 0000 and ptr holds its value.

Source files
------------

// File: rtl/ring_arbiter.sv
// ring_arbiter: 4-way rotating-priority arbiter with a bounded hold quantum.
//   clk      : clock, all state changes on the rising edge
//   clr      : asynchronous active-low reset
//   req[3:0] : level-sensitive request per requester
//   mask[3:0]: 1 = requester eligible
//   gnt[3:0] : one-hot grant (registered)
//   gnt_id   : encoded index of the holder, 0 when idle (registered)
//   ptr[3:0] : one-hot ring priority pointer (registered)
//   preempt  : one-cycle pulse when a grant ends by quantum expiry (registered)
module ring_arbiter #(
    parameter int unsigned QUANTUM = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] req,
    input  logic [3:0] mask,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic [3:0] ptr,
    output logic       preempt
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [3:0]       gnt_q,     gnt_d;
    logic [1:0]       gnt_id_q,  gnt_id_d;
    logic [3:0]       ptr_q,     ptr_d;
    logic             preempt_q, preempt_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic [3:0] elig;
    logic [1:0] ptr_idx;
    logic [1:0] cand;
    logic [1:0] win_idx;
    logic       win_found;

    assign elig = req & mask;

    // Winner search: start at the pointer bit and walk downward with wrap.
    // 2-bit subtraction provides the modulo-4 wrap for free.
    always_comb begin
        ptr_idx   = 2'd0;
        cand      = 2'd0;
        win_idx   = 2'd0;
        win_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ptr_q[i]) begin
                ptr_idx = 2'(i);
            end
        end
        for (int k = 0; k < 4; k++) begin
            cand = ptr_idx - 2'(k);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        preempt_d = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = GRANT;
                    gnt_d    = 4'(4'b0001 << win_idx);
                    gnt_id_d = win_idx;
                    // Winner drops to lowest priority: pointer sits one below it.
                    ptr_d    = 4'(4'b0001 << (win_idx - 2'd1));
                    cnt_d    = CNT_W'(1);
                end
            end
            GRANT: begin
                if (!elig[gnt_id_q]) begin
                    state_d  = GAP;
                    gnt_d    = 4'b0000;
                    gnt_id_d = 2'd0;
                end else if (cnt_q == CNT_W'(QUANTUM)) begin
                    state_d   = GAP;
                    gnt_d     = 4'b0000;
                    gnt_id_d  = 2'd0;
                    preempt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = 4'b0000;
                gnt_id_d = 2'd0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            gnt_id_q  <= 2'd0;
            ptr_q     <= 4'b1000;
            preempt_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            preempt_q <= preempt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign ptr     = ptr_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_ring_arbiter.sv
// tb_ring_arbiter: scoreboard bench for ring_arbiter (QUANTUM = 8).
module tb_ring_arbiter;

    localparam int unsigned Q = 8;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] req;
    logic [3:0] mask;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic [3:0] ptr;
    logic       preempt;

    ring_arbiter #(.QUANTUM(Q)) dut (
        .clk     (clk),
        .clr     (clr),
        .req     (req),
        .mask    (mask),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .ptr     (ptr),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic [3:0] ptr;
        logic       pre;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: ms 0=idle 1=grant 2=gap, mi holder, mp pointer index.
    int   ms, mh, mi, mp;
    logic mpre;

    logic [3:0] prev_gnt;
    int         start_id[$];
    logic [3:0] start_ptr[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms = 0; mh = 0; mi = 0; mp = 3; mpre = 1'b0;
        sb_q.delete();
        prev_gnt = 4'b0000;
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input logic [3:0] r, input logic [3:0] m);
        exp_t e;
        int   idx;
        bit   found;
        @(negedge clk);
        req  = r;
        mask = m;
        mpre = 1'b0;
        case (ms)
            0: begin
                found = 0;
                for (int k = 0; k < 4; k++) begin
                    idx = (mp - k + 4) % 4;
                    if (!found && r[idx] && m[idx]) begin
                        found = 1;
                        mi = idx;
                    end
                end
                if (found) begin
                    ms = 1; mh = 1; mp = (mi + 3) % 4;
                end
            end
            1: begin
                if (!(r[mi] && m[mi])) ms = 2;
                else if (mh == int'(Q)) begin ms = 2; mpre = 1'b1; end
                else mh++;
            end
            default: ms = 0;
        endcase
        e.gnt = (ms == 1) ? 4'(1 << mi) : 4'b0000;
        e.id  = (ms == 1) ? 2'(mi) : 2'd0;
        e.ptr = 4'(1 << mp);
        e.pre = mpre;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("sb_gnt",     32'(gnt),     32'(e.gnt));
        check_eq("sb_gnt_id",  32'(gnt_id),  32'(e.id));
        check_eq("sb_ptr",     32'(ptr),     32'(e.ptr));
        check_eq("sb_preempt", 32'(preempt), 32'(e.pre));
        if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
            start_id.push_back(int'(gnt_id));
            start_ptr.push_back(ptr);
        end
        prev_gnt = gnt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr  = 1'b0;
        req  = 4'b0000;
        mask = 4'b1111;
        model_reset();
        #1;
        check_eq("rst_gnt",     32'(gnt),     32'h0);
        check_eq("rst_gnt_id",  32'(gnt_id),  32'h0);
        check_eq("rst_ptr",     32'(ptr),     32'h8);
        check_eq("rst_preempt", 32'(preempt), 32'h0);
        @(negedge clk);
        clr = 1'b1;
        start_id.delete();
        start_ptr.delete();
    endtask

    int exp_ids28[5]  = '{3, 2, 1, 0, 3};
    int exp_ptr28[5]  = '{4, 2, 1, 8, 4};
    int exp_ids31[4]  = '{2, 0, 2, 0};
    int n, z;

    initial begin
        clr  = 1'b1;
        req  = 4'b0000;
        mask = 4'b0000;
        model_reset();

        // Full round-robin under all-request.
        do_reset();
        repeat (45) step(4'b1111, 4'b1111);
        check_eq("rr_grant_cnt", 32'(start_id.size()), 32'd5);
        for (int i = 0; i < 5 && i < start_id.size(); i++) begin
            check_eq($sformatf("rr_id%0d", i),  32'(start_id[i]),  32'(exp_ids28[i]));
            check_eq($sformatf("rr_ptr%0d", i), 32'(start_ptr[i]), 32'(exp_ptr28[i]));
        end

        // Lone requester: quantum preemption, two-cycle gap, regrant.
        do_reset();
        step(4'b0001, 4'b1111);
        for (int rep = 0; rep < 2; rep++) begin
            n = 0;
            while (gnt == 4'b0001 && n < 20) begin
                n++;
                step(4'b0001, 4'b1111);
            end
            check_eq($sformatf("q_run_len%0d", rep), 32'(n), 32'(Q));
            check_eq($sformatf("q_preempt%0d", rep), 32'(preempt), 32'h1);
            z = 0;
            while (gnt == 4'b0000 && z < 20) begin
                z++;
                step(4'b0001, 4'b1111);
            end
            check_eq($sformatf("q_gap_len%0d", rep), 32'(z), 32'd2);
            check_eq($sformatf("q_regrant%0d", rep), 32'(gnt), 32'h1);
        end

        // Holder 2 drops on its 3rd grant cycle.
        do_reset();
        step(4'b0111, 4'b1111);
        check_eq("drop_first", 32'(gnt), 32'h4);
        step(4'b0111, 4'b1111);
        step(4'b0111, 4'b1111);
        step(4'b0011, 4'b1111);
        check_eq("drop_gnt",     32'(gnt),     32'h0);
        check_eq("drop_preempt", 32'(preempt), 32'h0);
        step(4'b0011, 4'b1111);
        step(4'b0011, 4'b1111);
        check_eq("drop_next_id", 32'(gnt_id), 32'd1);

        // Mask leaves only 2 and 0 eligible.
        do_reset();
        repeat (40) step(4'b1111, 4'b0101);
        check_eq("mask_grant_cnt", 32'(start_id.size()), 32'd4);
        for (int i = 0; i < 4 && i < start_id.size(); i++)
            check_eq($sformatf("mask_id%0d", i), 32'(start_id[i]), 32'(exp_ids31[i]));

        // Asynchronous reset mid-grant of index 1.
        do_reset();
        step(4'b0010, 4'b1111);
        step(4'b0010, 4'b1111);
        check_eq("clr_pre_gnt", 32'(gnt), 32'h2);
        #3;
        clr = 1'b0;
        #1;
        check_eq("clr_gnt",     32'(gnt),     32'h0);
        check_eq("clr_gnt_id",  32'(gnt_id),  32'h0);
        check_eq("clr_ptr",     32'(ptr),     32'h8);
        check_eq("clr_preempt", 32'(preempt), 32'h0);
        model_reset();
        @(negedge clk);
        clr = 1'b1;
        req = 4'b0000;
        step(4'b0010, 4'b1111);
        check_eq("clr_first_arb", 32'(gnt), 32'h2);

        // Quiet bus for 20 cycles: pointer must hold.
        repeat (20) step(4'b0000, 4'b1111);
        check_eq("quiet_gnt", 32'(gnt), 32'h0);
        check_eq("quiet_ptr", 32'(ptr), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
